// File: rtl/alu_rs.sv
// alu_rs: reservation station holding ALU instructions until operands resolve, then dispatching one per cycle.
// Ports: clk/rst/rdy/clear control; issue_* new instruction from dispatcher; rs_full when all entries busy;
//        alu_cdb_*/lsb_cdb_* result broadcast buses snooped for pending operands;
//        alu_en + alu_* registered dispatch strobe and payload to the ALU.
module alu_rs #(
    parameter int RS_SIZE = 8,
    parameter int ROB_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clear,
    input  logic             issue_en,
    input  logic [ROB_W-1:0] issue_rob_id,
    input  logic [5:0]       issue_opcode,
    input  logic [31:0]      issue_vj,
    input  logic [31:0]      issue_vk,
    input  logic             issue_qj_busy,
    input  logic             issue_qk_busy,
    input  logic [ROB_W-1:0] issue_qj,
    input  logic [ROB_W-1:0] issue_qk,
    input  logic [31:0]      issue_imm,
    input  logic [31:0]      issue_pc,
    output logic             rs_full,
    input  logic             alu_cdb_valid,
    input  logic [ROB_W-1:0] alu_cdb_rob_id,
    input  logic [31:0]      alu_cdb_val,
    input  logic             lsb_cdb_valid,
    input  logic [ROB_W-1:0] lsb_cdb_rob_id,
    input  logic [31:0]      lsb_cdb_val,
    output logic             alu_en,
    output logic [ROB_W-1:0] alu_rob_id,
    output logic [5:0]       alu_opcode,
    output logic [31:0]      alu_rs1,
    output logic [31:0]      alu_rs2,
    output logic [31:0]      alu_imm,
    output logic [31:0]      alu_pc
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] busy_q, busy_d, qjb_q, qjb_d, qkb_q, qkb_d, ready;
    logic [5:0]         op_q  [RS_SIZE];
    logic [5:0]         op_d  [RS_SIZE];
    logic [ROB_W-1:0]   rob_q [RS_SIZE];
    logic [ROB_W-1:0]   rob_d [RS_SIZE];
    logic [ROB_W-1:0]   qj_q  [RS_SIZE];
    logic [ROB_W-1:0]   qj_d  [RS_SIZE];
    logic [ROB_W-1:0]   qk_q  [RS_SIZE];
    logic [ROB_W-1:0]   qk_d  [RS_SIZE];
    logic [31:0]        vj_q  [RS_SIZE];
    logic [31:0]        vj_d  [RS_SIZE];
    logic [31:0]        vk_q  [RS_SIZE];
    logic [31:0]        vk_d  [RS_SIZE];
    logic [31:0]        imm_q [RS_SIZE];
    logic [31:0]        imm_d [RS_SIZE];
    logic [31:0]        pc_q  [RS_SIZE];
    logic [31:0]        pc_d  [RS_SIZE];

    logic             en_q, en_d;
    logic [ROB_W-1:0] o_rob_q, o_rob_d;
    logic [5:0]       o_op_q, o_op_d;
    logic [31:0]      o_rs1_q, o_rs1_d, o_rs2_q, o_rs2_d, o_imm_q, o_imm_d, o_pc_q, o_pc_d;

    logic             has_ready;
    logic [IDX_W-1:0] sel, free_idx;

    // Issue-time bypass: a pending operand whose producer broadcasts this cycle is captured directly.
    logic        j_alu, j_lsb, k_alu, k_lsb, in_qjb, in_qkb;
    logic [31:0] in_vj, in_vk;

    assign j_alu  = issue_qj_busy && alu_cdb_valid && alu_cdb_rob_id == issue_qj;
    assign j_lsb  = issue_qj_busy && lsb_cdb_valid && lsb_cdb_rob_id == issue_qj;
    assign k_alu  = issue_qk_busy && alu_cdb_valid && alu_cdb_rob_id == issue_qk;
    assign k_lsb  = issue_qk_busy && lsb_cdb_valid && lsb_cdb_rob_id == issue_qk;
    assign in_vj  = j_alu ? alu_cdb_val : j_lsb ? lsb_cdb_val : issue_vj;
    assign in_vk  = k_alu ? alu_cdb_val : k_lsb ? lsb_cdb_val : issue_vk;
    assign in_qjb = issue_qj_busy && !j_alu && !j_lsb;
    assign in_qkb = issue_qk_busy && !k_alu && !k_lsb;

    assign ready   = busy_q & ~qjb_q & ~qkb_q;
    assign rs_full = &busy_q;

    // Descending scan so the lowest index wins both encoders.
    always_comb begin
        has_ready = 1'b0;
        sel       = '0;
        free_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                has_ready = 1'b1;
                sel       = IDX_W'(i);
            end
            if (!busy_q[i]) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        busy_d = busy_q;
        qjb_d  = qjb_q;
        qkb_d  = qkb_q;
        op_d   = op_q;
        rob_d  = rob_q;
        qj_d   = qj_q;
        qk_d   = qk_q;
        vj_d   = vj_q;
        vk_d   = vk_q;
        imm_d  = imm_q;
        pc_d   = pc_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i] && qjb_q[i]) begin
                if (alu_cdb_valid && alu_cdb_rob_id == qj_q[i]) begin
                    vj_d[i]  = alu_cdb_val;
                    qjb_d[i] = 1'b0;
                end else if (lsb_cdb_valid && lsb_cdb_rob_id == qj_q[i]) begin
                    vj_d[i]  = lsb_cdb_val;
                    qjb_d[i] = 1'b0;
                end
            end
            if (busy_q[i] && qkb_q[i]) begin
                if (alu_cdb_valid && alu_cdb_rob_id == qk_q[i]) begin
                    vk_d[i]  = alu_cdb_val;
                    qkb_d[i] = 1'b0;
                end else if (lsb_cdb_valid && lsb_cdb_rob_id == qk_q[i]) begin
                    vk_d[i]  = lsb_cdb_val;
                    qkb_d[i] = 1'b0;
                end
            end
        end
        if (has_ready) busy_d[sel] = 1'b0;
        // rs_full uses registered busy bits, so the slot freed by this edge's dispatch is not reused yet.
        if (issue_en && !rs_full) begin
            busy_d[free_idx] = 1'b1;
            op_d[free_idx]   = issue_opcode;
            rob_d[free_idx]  = issue_rob_id;
            qj_d[free_idx]   = issue_qj;
            qk_d[free_idx]   = issue_qk;
            qjb_d[free_idx]  = in_qjb;
            qkb_d[free_idx]  = in_qkb;
            vj_d[free_idx]   = in_vj;
            vk_d[free_idx]   = in_vk;
            imm_d[free_idx]  = issue_imm;
            pc_d[free_idx]   = issue_pc;
        end
        if (clear) busy_d = '0;
    end

    always_comb begin
        en_d    = has_ready && !clear;
        o_rob_d = en_d ? rob_q[sel] : o_rob_q;
        o_op_d  = en_d ? op_q[sel]  : o_op_q;
        o_rs1_d = en_d ? vj_q[sel]  : o_rs1_q;
        o_rs2_d = en_d ? vk_q[sel]  : o_rs2_q;
        o_imm_d = en_d ? imm_q[sel] : o_imm_q;
        o_pc_d  = en_d ? pc_q[sel]  : o_pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            qjb_q   <= '0;
            qkb_q   <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_q[i]  <= '0;
                rob_q[i] <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                imm_q[i] <= '0;
                pc_q[i]  <= '0;
            end
            en_q    <= 1'b0;
            o_rob_q <= '0;
            o_op_q  <= '0;
            o_rs1_q <= '0;
            o_rs2_q <= '0;
            o_imm_q <= '0;
            o_pc_q  <= '0;
        end else if (rdy) begin
            busy_q  <= busy_d;
            qjb_q   <= qjb_d;
            qkb_q   <= qkb_d;
            op_q    <= op_d;
            rob_q   <= rob_d;
            qj_q    <= qj_d;
            qk_q    <= qk_d;
            vj_q    <= vj_d;
            vk_q    <= vk_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            en_q    <= en_d;
            o_rob_q <= o_rob_d;
            o_op_q  <= o_op_d;
            o_rs1_q <= o_rs1_d;
            o_rs2_q <= o_rs2_d;
            o_imm_q <= o_imm_d;
            o_pc_q  <= o_pc_d;
        end
    end

    assign alu_en     = en_q;
    assign alu_rob_id = o_rob_q;
    assign alu_opcode = o_op_q;
    assign alu_rs1    = o_rs1_q;
    assign alu_rs2    = o_rs2_q;
    assign alu_imm    = o_imm_q;
    assign alu_pc     = o_pc_q;
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: scoreboard bench for alu_rs; expected dispatches carry payload and the cycle they must appear in.
module tb_alu_rs;
    logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1, clear = 1'b0;
    logic        issue_en = 1'b0, issue_qj_busy = 1'b0, issue_qk_busy = 1'b0;
    logic [3:0]  issue_rob_id = '0, issue_qj = '0, issue_qk = '0;
    logic [5:0]  issue_opcode = '0;
    logic [31:0] issue_vj = '0, issue_vk = '0, issue_imm = '0, issue_pc = '0;
    logic        rs_full;
    logic        alu_cdb_valid = 1'b0, lsb_cdb_valid = 1'b0;
    logic [3:0]  alu_cdb_rob_id = '0, lsb_cdb_rob_id = '0;
    logic [31:0] alu_cdb_val = '0, lsb_cdb_val = '0;
    logic        alu_en;
    logic [3:0]  alu_rob_id;
    logic [5:0]  alu_opcode;
    logic [31:0] alu_rs1, alu_rs2, alu_imm, alu_pc;

    typedef struct {
        logic [3:0]  rob;
        logic [5:0]  op;
        logic [31:0] rs1, rs2, imm, pc;
        int          cyc;
    } disp_t;

    disp_t sb[$];
    int    cyc = 0, checks = 0, errors = 0;

    alu_rs dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .issue_en(issue_en), .issue_rob_id(issue_rob_id), .issue_opcode(issue_opcode),
        .issue_vj(issue_vj), .issue_vk(issue_vk),
        .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
        .issue_qj(issue_qj), .issue_qk(issue_qk),
        .issue_imm(issue_imm), .issue_pc(issue_pc), .rs_full(rs_full),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_id(alu_cdb_rob_id), .alu_cdb_val(alu_cdb_val),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_val(lsb_cdb_val),
        .alu_en(alu_en), .alu_rob_id(alu_rob_id), .alu_opcode(alu_opcode),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm), .alu_pc(alu_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && alu_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_dispatch_rob", {60'd0, alu_rob_id}, 64'hffff);
            end else begin
                disp_t e;
                e = sb.pop_front();
                chk("disp_cycle", 64'(cyc), 64'(e.cyc));
                chk("disp_rob", {60'd0, alu_rob_id}, {60'd0, e.rob});
                chk("disp_op", {58'd0, alu_opcode}, {58'd0, e.op});
                chk("disp_rs1", {32'd0, alu_rs1}, {32'd0, e.rs1});
                chk("disp_rs2", {32'd0, alu_rs2}, {32'd0, e.rs2});
                chk("disp_imm", {32'd0, alu_imm}, {32'd0, e.imm});
                chk("disp_pc", {32'd0, alu_pc}, {32'd0, e.pc});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_en = 1'b0; issue_qj_busy = 1'b0; issue_qk_busy = 1'b0;
        alu_cdb_valid = 1'b0; lsb_cdb_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic iss(input logic [3:0] rob, input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic qjb, input logic [3:0] qj, input logic qkb, input logic [3:0] qk,
                       input logic [31:0] imm, input logic [31:0] pc);
        issue_en = 1'b1; issue_rob_id = rob; issue_opcode = op; issue_vj = vj; issue_vk = vk;
        issue_qj_busy = qjb; issue_qj = qj; issue_qk_busy = qkb; issue_qk = qk;
        issue_imm = imm; issue_pc = pc;
    endtask

    task automatic exp_push(input logic [3:0] rob, input logic [5:0] op, input logic [31:0] rs1,
                            input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] pc, input int at);
        disp_t e;
        e.rob = rob; e.op = op; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.pc = pc; e.cyc = at;
        sb.push_back(e);
    endtask

    initial begin
        int c;
        repeat (3) step();
        chk("rst_alu_en", {63'd0, alu_en}, 64'd0);
        chk("rst_rob", {60'd0, alu_rob_id}, 64'd0);
        chk("rst_op", {58'd0, alu_opcode}, 64'd0);
        chk("rst_rs1", {32'd0, alu_rs1}, 64'd0);
        chk("rst_rs2", {32'd0, alu_rs2}, 64'd0);
        chk("rst_imm", {32'd0, alu_imm}, 64'd0);
        chk("rst_pc", {32'd0, alu_pc}, 64'd0);
        chk("rst_full", {63'd0, rs_full}, 64'd0);
        rst = 1'b0;
        step();

        // both operands ready: dispatch two edges after issue
        iss(4'd3, 6'h01, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 32'h11, 32'h100);
        exp_push(4'd3, 6'h01, 32'd5, 32'd7, 32'h11, 32'h100, cyc + 2);
        step(); idle(); repeat (3) step();

        // pending j resolved by ALU CDB two cycles later
        iss(4'd5, 6'h02, 32'hdead, 32'd9, 1'b1, 4'd2, 1'b0, 4'd0, 32'h22, 32'h104);
        step(); idle(); step();
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd2; alu_cdb_val = 32'h10;
        exp_push(4'd5, 6'h02, 32'h10, 32'd9, 32'h22, 32'h104, cyc + 2);
        step(); idle(); repeat (3) step();

        // issue-time bypass from LSB CDB on k
        iss(4'd6, 6'h03, 32'd1, 32'hbeef, 1'b0, 4'd0, 1'b1, 4'd4, 32'h33, 32'h108);
        lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 4'd4; lsb_cdb_val = 32'hab;
        exp_push(4'd6, 6'h03, 32'd1, 32'hab, 32'h33, 32'h108, cyc + 2);
        step(); idle(); repeat (3) step();

        // issue-time bypass with both buses matching: ALU bus wins
        iss(4'd7, 6'h04, 32'hbad, 32'd2, 1'b1, 4'd7, 1'b0, 4'd0, 32'h44, 32'h10c);
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd7; alu_cdb_val = 32'h77;
        lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 4'd7; lsb_cdb_val = 32'h88;
        exp_push(4'd7, 6'h04, 32'h77, 32'd2, 32'h44, 32'h10c, cyc + 2);
        step(); idle(); repeat (3) step();

        // fill all entries with pending j (tags 8..15), entry i gets rob i
        for (int i = 0; i < 8; i++) begin
            chk("fill_not_full", {63'd0, rs_full}, 64'd0);
            iss(4'(i), 6'h05, 32'd0, 32'(i + 100), 1'b1, 4'(i + 8), 1'b0, 4'd0, 32'(i), 32'(32'h200 + i * 4));
            step();
        end
        idle();
        chk("full_after_fill", {63'd0, rs_full}, 64'd1);
        iss(4'd15, 6'h06, 32'h99, 32'h99, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 32'h300);
        step(); idle();
        chk("full_after_drop", {63'd0, rs_full}, 64'd1);
        step();

        // resolve entries 5 (ALU bus, tag 13) and 2 (LSB bus, tag 10) together
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd13; alu_cdb_val = 32'h55;
        lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 4'd10; lsb_cdb_val = 32'h22;
        c = cyc;
        exp_push(4'd2, 6'h05, 32'h22, 32'd102, 32'd2, 32'h208, c + 2);
        exp_push(4'd5, 6'h05, 32'h55, 32'd105, 32'd5, 32'h214, c + 3);
        step(); idle();
        chk("full_at_cdb_edge", {63'd0, rs_full}, 64'd1);
        step();
        chk("full_after_dispatch", {63'd0, rs_full}, 64'd0);
        step();

        // clear with simultaneous issue and CDB while 6 entries are busy
        clear = 1'b1;
        iss(4'd9, 6'h07, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 32'h400);
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd8; alu_cdb_val = 32'h88;
        step(); idle();
        chk("clear_alu_en", {63'd0, alu_en}, 64'd0);
        chk("clear_not_full", {63'd0, rs_full}, 64'd0);
        // normal issue after clear; broadcasting old tags must not revive flushed entries
        iss(4'd12, 6'h08, 32'h12, 32'h34, 1'b0, 4'd0, 1'b0, 4'd0, 32'h56, 32'h500);
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd9; alu_cdb_val = 32'h9;
        exp_push(4'd12, 6'h08, 32'h12, 32'h34, 32'h56, 32'h500, cyc + 2);
        step(); idle();
        lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 4'd11; lsb_cdb_val = 32'hb;
        step(); idle(); repeat (4) step();

        // rdy low for 3 edges with a ready entry; activity during hold is ignored
        iss(4'd1, 6'h09, 32'h31, 32'h32, 1'b0, 4'd0, 1'b0, 4'd0, 32'h33, 32'h600);
        exp_push(4'd1, 6'h09, 32'h31, 32'h32, 32'h33, 32'h600, cyc + 5);
        step();
        rdy = 1'b0;
        iss(4'd2, 6'h0a, 32'h41, 32'h42, 1'b0, 4'd0, 1'b0, 4'd0, 32'h43, 32'h700);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_alu_en", {63'd0, alu_en}, 64'd0);
        end
        idle(); rdy = 1'b1;
        repeat (6) step();

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
